// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared arbiter state encoding and requester IDs for the memory port
package cpu_mem_pkg;
    typedef enum logic [2:0] {
        IDLE,
        REQ_IF,
        REQ_MEM,
        WAIT_IF,
        WAIT_MEM,
        DRAIN
    } arb_state_t;
    localparam logic REQ_ID_IF  = 1'b0;
    localparam logic REQ_ID_MEM = 1'b1;
endpackage

// File: rtl/bus_timeout_counter.sv
// bus_timeout_counter: counts in-flight cycles and flags the last allowed one
module bus_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    input  logic clear,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);
    localparam logic [W-1:0] CAP  = W'(TIMEOUT);

    logic [W-1:0] cnt_q, cnt_d;

    // Count while running, hold at TIMEOUT so the counter never wraps
    always_comb begin
        cnt_d = clear ? '0 : (run && cnt_q != CAP) ? cnt_q + W'(1) : cnt_q;
    end

    // Counter register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    // Expired during the TIMEOUT-th running cycle, so the fault pulse lands TIMEOUT cycles after entry
    assign expired = run && !clear && cnt_q == LAST;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory bus between instruction fetch and load/store
module mem_port_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int MAX_MEM_BURST = 4,
    parameter int TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_fault,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_rvalid,
    output logic [31:0] mem_rdata,
    output logic        mem_fault,
    output logic        stall_IF,
    output logic        stall_MEM,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    input  logic        bus_gnt,
    input  logic        bus_rvalid,
    input  logic [31:0] bus_rdata
);
    localparam int SW = $clog2(MAX_MEM_BURST + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_MEM_BURST);

    arb_state_t    state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic          bus_we_q, bus_we_d;
    logic [31:0]   bus_addr_q, bus_addr_d;
    logic [31:0]   bus_wdata_q, bus_wdata_d;
    logic [3:0]    bus_wstrb_q, bus_wstrb_d;
    logic          if_rvalid_q, if_rvalid_d;
    logic          if_fault_q, if_fault_d;
    logic [31:0]   if_rdata_q, if_rdata_d;
    logic          mem_rvalid_q, mem_rvalid_d;
    logic          mem_fault_q, mem_fault_d;
    logic [31:0]   mem_rdata_q, mem_rdata_d;
    logic          in_flight, expired, win_id;

    assign in_flight = state_q inside {WAIT_IF, WAIT_MEM, DRAIN};

    bus_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .reset   (reset),
        .run     (in_flight),
        .clear   (!in_flight),
        .expired (expired)
    );

    // MEM has priority unless IF has already waited through MAX_MEM_BURST MEM grants
    assign win_id = (if_req && (!mem_req || starve_q == STARVE_MAX)) ? REQ_ID_IF : REQ_ID_MEM;

    // Next-state and registered-output logic for the single-outstanding transaction FSM
    always_comb begin
        state_d      = state_q;
        starve_d     = starve_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_wdata_d  = bus_wdata_q;
        bus_wstrb_d  = bus_wstrb_q;
        if_rdata_d   = if_rdata_q;
        mem_rdata_d  = mem_rdata_q;
        if_rvalid_d  = 1'b0;
        if_fault_d   = 1'b0;
        mem_rvalid_d = 1'b0;
        mem_fault_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (if_req || mem_req) begin
                    state_d     = (win_id == REQ_ID_IF) ? REQ_IF : REQ_MEM;
                    bus_we_d    = (win_id == REQ_ID_MEM) && mem_we;
                    bus_addr_d  = (win_id == REQ_ID_IF) ? if_addr : mem_addr;
                    bus_wdata_d = (win_id == REQ_ID_IF) ? '0 : mem_wdata;
                    bus_wstrb_d = (win_id == REQ_ID_IF) ? '0 : mem_wstrb;
                    starve_d    = (win_id == REQ_ID_MEM && if_req)
                                ? ((starve_q == STARVE_MAX) ? starve_q : starve_q + SW'(1))
                                : '0;
                end
            end
            REQ_IF: begin
                // A flush racing the grant still leaves a fetch in flight, so it must drain
                state_d = if_flush ? (bus_gnt ? DRAIN : IDLE) : (bus_gnt ? WAIT_IF : REQ_IF);
            end
            REQ_MEM: begin
                state_d = bus_gnt ? WAIT_MEM : REQ_MEM;
            end
            WAIT_IF: begin
                if (bus_rvalid || expired) begin
                    state_d     = IDLE;
                    if_rvalid_d = !if_flush;
                    if_fault_d  = !if_flush && !bus_rvalid;
                    if_rdata_d  = bus_rvalid ? bus_rdata : '0;
                end else if (if_flush) begin
                    state_d = DRAIN;
                end
            end
            WAIT_MEM: begin
                if (bus_rvalid || expired) begin
                    state_d      = IDLE;
                    mem_rvalid_d = 1'b1;
                    mem_fault_d  = !bus_rvalid;
                    mem_rdata_d  = bus_rvalid ? bus_rdata : '0;
                end
            end
            DRAIN: begin
                if (bus_rvalid || expired) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            starve_q     <= '0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            bus_wstrb_q  <= '0;
            if_rvalid_q  <= 1'b0;
            if_fault_q   <= 1'b0;
            if_rdata_q   <= '0;
            mem_rvalid_q <= 1'b0;
            mem_fault_q  <= 1'b0;
            mem_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            starve_q     <= starve_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            bus_wstrb_q  <= bus_wstrb_d;
            if_rvalid_q  <= if_rvalid_d;
            if_fault_q   <= if_fault_d;
            if_rdata_q   <= if_rdata_d;
            mem_rvalid_q <= mem_rvalid_d;
            mem_fault_q  <= mem_fault_d;
            mem_rdata_q  <= mem_rdata_d;
        end
    end

    assign bus_req    = state_q inside {REQ_IF, REQ_MEM};
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_wdata  = bus_wdata_q;
    assign bus_wstrb  = bus_wstrb_q;
    // A flush in the same cycle as the fetch response kills that response
    assign if_rvalid  = if_rvalid_q && !if_flush;
    assign if_fault   = if_fault_q && !if_flush;
    assign if_rdata   = if_rdata_q;
    assign mem_rvalid = mem_rvalid_q;
    assign mem_fault  = mem_fault_q;
    assign mem_rdata  = mem_rdata_q;
    assign stall_IF   = if_req && !if_rvalid;
    assign stall_MEM  = mem_req && !mem_rvalid;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scenario tasks with a response scoreboard for mem_port_arbiter
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        if_req, if_flush, mem_req, mem_we, bus_gnt, bus_rvalid;
    logic [31:0] if_addr, mem_addr, mem_wdata, bus_rdata;
    logic [3:0]  mem_wstrb;
    logic        if_rvalid, if_fault, mem_rvalid, mem_fault, stall_IF, stall_MEM;
    logic        bus_req, bus_we;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;

    typedef struct {
        logic        is_mem;
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        fault;
    } rsp_t;

    rsp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mem_port_arbiter #(.MAX_MEM_BURST(4), .TIMEOUT(8)) dut (
        .clk        (clk),
        .reset      (reset_n),
        .if_req     (if_req),
        .if_addr    (if_addr),
        .if_flush   (if_flush),
        .if_rvalid  (if_rvalid),
        .if_rdata   (if_rdata),
        .if_fault   (if_fault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_fault  (mem_fault),
        .stall_IF   (stall_IF),
        .stall_MEM  (stall_MEM),
        .bus_req    (bus_req),
        .bus_we     (bus_we),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_wstrb  (bus_wstrb),
        .bus_gnt    (bus_gnt),
        .bus_rvalid (bus_rvalid),
        .bus_rdata  (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bus slave: wait (bounded) for a request, grant at once, respond next cycle, sample the response cycle
    task automatic serve(input logic [31:0] rdata, output logic seen, output logic [31:0] a,
                         output logic we, output logic iv, output logic mv,
                         output logic [31:0] rd, output logic flt);
        int n = 0;
        while (!bus_req && n < 20) begin
            tick();
            n++;
        end
        seen = bus_req;
        a = bus_addr;
        we = bus_we;
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        bus_rvalid = 1'b1;
        bus_rdata = rdata;
        tick();
        bus_rvalid = 1'b0;
        iv = if_rvalid;
        mv = mem_rvalid;
        rd = mem_rvalid ? mem_rdata : if_rdata;
        flt = mem_rvalid ? mem_fault : if_fault;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        if_req = 1'b1; if_flush = 1'b0; if_addr = 32'h0;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h0; mem_wdata = 32'h0; mem_wstrb = 4'h0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'h0;
        tick();
        tick();
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb, if_rvalid, if_rdata, if_fault,
             mem_rvalid, mem_rdata, mem_fault} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: bus_req=%b bus_addr=%h if_rvalid=%b mem_rvalid=%b, all required 0",
                     bus_req, bus_addr, if_rvalid, mem_rvalid);
        end
        checks++;
        if ({stall_IF, stall_MEM} !== 2'b11) begin
            errors++;
            $display("FAIL reset_stall: got %b%b required 11", stall_IF, stall_MEM);
        end
        if_req = 1'b0;
        mem_req = 1'b0;
        mem_we = 1'b0;
        reset_n = 1'b1;
        tick();
        checks++;
        if (bus_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: bus_req=%b required 0", bus_req);
        end
    endtask

    task automatic test_single_fetch();
        logic seen, we, iv, mv, flt;
        logic [31:0] a, rd;
        rsp_t e;
        if_req = 1'b1;
        if_addr = 32'h100;
        sb.push_back('{is_mem: 1'b0, we: 1'b0, addr: 32'h100, data: 32'h13, fault: 1'b0});
        tick();
        checks++;
        if (bus_req !== 1'b1 || stall_IF !== 1'b1) begin
            errors++;
            $display("FAIL single_req_latency: bus_req=%b stall_IF=%b required 1 1", bus_req, stall_IF);
        end
        serve(32'h0000_0013, seen, a, we, iv, mv, rd, flt);
        e = sb.pop_front();
        checks++;
        if (!seen || a !== e.addr || we !== e.we) begin
            errors++;
            $display("FAIL single_bus: req=%b addr=%h we=%b required addr=%h we=%b", seen, a, we, e.addr, e.we);
        end
        checks++;
        if (iv !== !e.is_mem || mv !== e.is_mem || rd !== e.data || flt !== e.fault) begin
            errors++;
            $display("FAIL single_rsp: if_rvalid=%b mem_rvalid=%b data=%h fault=%b required data=%h fault=%b",
                     iv, mv, rd, flt, e.data, e.fault);
        end
        checks++;
        if (stall_IF !== 1'b0) begin
            errors++;
            $display("FAIL single_stall_release: stall_IF=%b required 0", stall_IF);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_contention();
        logic seen, we, iv, mv, flt;
        logic [31:0] a, rd;
        rsp_t e;
        if_req = 1'b1; if_addr = 32'h100;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h2000;
        sb.push_back('{is_mem: 1'b1, we: 1'b0, addr: 32'h2000, data: 32'h1111_2222, fault: 1'b0});
        sb.push_back('{is_mem: 1'b0, we: 1'b0, addr: 32'h100, data: 32'h0000_0093, fault: 1'b0});
        serve(32'h1111_2222, seen, a, we, iv, mv, rd, flt);
        e = sb.pop_front();
        checks++;
        if (!seen || a !== e.addr || we !== e.we) begin
            errors++;
            $display("FAIL contention_first_bus: addr=%h we=%b required addr=%h we=%b", a, we, e.addr, e.we);
        end
        checks++;
        if (iv !== !e.is_mem || mv !== e.is_mem || rd !== e.data) begin
            errors++;
            $display("FAIL contention_first_rsp: if_rvalid=%b mem_rvalid=%b data=%h required data=%h", iv, mv, rd, e.data);
        end
        checks++;
        if (stall_IF !== 1'b1) begin
            errors++;
            $display("FAIL contention_stall_IF: stall_IF=%b required 1", stall_IF);
        end
        mem_req = 1'b0;
        serve(32'h0000_0093, seen, a, we, iv, mv, rd, flt);
        e = sb.pop_front();
        checks++;
        if (!seen || a !== e.addr || iv !== 1'b1 || mv !== 1'b0 || rd !== e.data) begin
            errors++;
            $display("FAIL contention_second: addr=%h if_rvalid=%b data=%h required addr=%h data=%h",
                     a, iv, rd, e.addr, e.data);
        end
        if_req = 1'b0;
        tick();
    endtask

    task automatic test_starvation();
        logic seen, we, iv, mv, flt;
        logic [31:0] a, rd;
        rsp_t e;
        if_req = 1'b1; if_addr = 32'h104;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h3000;
        for (int i = 0; i < 6; i++) begin
            if (i == 4) sb.push_back('{is_mem: 1'b0, we: 1'b0, addr: 32'h104, data: 32'hA0 + i, fault: 1'b0});
            else        sb.push_back('{is_mem: 1'b1, we: 1'b0, addr: 32'h3000 + 4 * (i > 4 ? 4 : i),
                                       data: 32'hA0 + i, fault: 1'b0});
            serve(32'hA0 + i, seen, a, we, iv, mv, rd, flt);
            e = sb.pop_front();
            checks++;
            if (!seen || a !== e.addr || iv !== !e.is_mem || mv !== e.is_mem || rd !== e.data) begin
                errors++;
                $display("FAIL starvation_grant%0d: addr=%h if_rvalid=%b mem_rvalid=%b data=%h required addr=%h is_mem=%b data=%h",
                         i + 1, a, iv, mv, rd, e.addr, e.is_mem, e.data);
            end
            if (i < 3) mem_addr = 32'h3000 + 4 * (i + 1);
            else if (i == 3) mem_addr = 32'h3010;
            else if (i == 4) if_req = 1'b0;
            else mem_req = 1'b0;
        end
        tick();
    endtask

    task automatic test_flush();
        logic seen, we, iv, mv, flt;
        logic [31:0] a, rd;
        logic leak;
        rsp_t e;
        if_req = 1'b1; if_addr = 32'h200;
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        if_flush = 1'b1;
        if_addr = 32'h300;
        tick();
        if_flush = 1'b0;
        leak = bus_req | if_rvalid;
        tick();
        leak |= bus_req | if_rvalid;
        tick();
        leak |= bus_req | if_rvalid;
        bus_rvalid = 1'b1;
        bus_rdata = 32'hDEAD_BEEF;
        tick();
        bus_rvalid = 1'b0;
        leak |= bus_req | if_rvalid;
        checks++;
        if (leak !== 1'b0) begin
            errors++;
            $display("FAIL flush_wait_drain: bus_req/if_rvalid seen=%b during drain, required 0", leak);
        end
        sb.push_back('{is_mem: 1'b0, we: 1'b0, addr: 32'h300, data: 32'h0000_0067, fault: 1'b0});
        serve(32'h0000_0067, seen, a, we, iv, mv, rd, flt);
        e = sb.pop_front();
        checks++;
        if (!seen || a !== e.addr || iv !== 1'b1 || rd !== e.data) begin
            errors++;
            $display("FAIL flush_next_fetch: addr=%h if_rvalid=%b data=%h required addr=%h data=%h",
                     a, iv, rd, e.addr, e.data);
        end
        if_req = 1'b0;
        tick();
        if_req = 1'b1; if_addr = 32'h400;
        tick();
        checks++;
        if (bus_req !== 1'b1 || bus_addr !== 32'h400) begin
            errors++;
            $display("FAIL flush_req_issue: bus_req=%b addr=%h required 1 00000400", bus_req, bus_addr);
        end
        if_flush = 1'b1;
        if_addr = 32'h500;
        tick();
        if_flush = 1'b0;
        checks++;
        if (bus_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_req_withdraw: bus_req=%b required 0", bus_req);
        end
        sb.push_back('{is_mem: 1'b0, we: 1'b0, addr: 32'h500, data: 32'h0000_0EF0, fault: 1'b0});
        serve(32'h0000_0EF0, seen, a, we, iv, mv, rd, flt);
        e = sb.pop_front();
        checks++;
        if (!seen || a !== e.addr || iv !== 1'b1 || rd !== e.data) begin
            errors++;
            $display("FAIL flush_req_refetch: addr=%h if_rvalid=%b data=%h required addr=%h data=%h",
                     a, iv, rd, e.addr, e.data);
        end
        if_flush = 1'b1;
        if_req = 1'b0;
        #1;
        checks++;
        if (if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL flush_coincident: if_rvalid=%b required 0", if_rvalid);
        end
        tick();
        if_flush = 1'b0;
        tick();
    endtask

    task automatic test_timeout();
        int k = 0;
        rsp_t e;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h4000; mem_wdata = 32'hCAFE_BABE; mem_wstrb = 4'b0110;
        tick();
        checks++;
        if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_addr !== 32'h4000 ||
            bus_wdata !== 32'hCAFE_BABE || bus_wstrb !== 4'b0110) begin
            errors++;
            $display("FAIL timeout_store_payload: req=%b we=%b addr=%h wdata=%h wstrb=%b required 1 1 4000 cafebabe 0110",
                     bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb);
        end
        bus_gnt = 1'b1;
        sb.push_back('{is_mem: 1'b1, we: 1'b1, addr: 32'h4000, data: 32'h0, fault: 1'b1});
        tick();
        bus_gnt = 1'b0;
        while (!mem_rvalid && k < 20) begin
            tick();
            k++;
        end
        e = sb.pop_front();
        checks++;
        if (k !== 8) begin
            errors++;
            $display("FAIL timeout_latency: fault pulse after %0d cycles in WAIT, required 8", k);
        end
        checks++;
        if (mem_rvalid !== 1'b1 || mem_fault !== e.fault || mem_rdata !== e.data || stall_MEM !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fault: rvalid=%b fault=%b rdata=%h stall_MEM=%b required 1 %b %h 0",
                     mem_rvalid, mem_fault, mem_rdata, stall_MEM, e.fault, e.data);
        end
        mem_req = 1'b0;
        mem_we = 1'b0;
        tick();
        checks++;
        if (bus_req !== 1'b0 || mem_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL timeout_idle: bus_req=%b mem_rvalid=%b required 0 0", bus_req, mem_rvalid);
        end
    endtask

    task automatic test_reset_in_wait();
        logic seen, we, iv, mv, flt;
        logic [31:0] a, rd;
        rsp_t e;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h5000;
        tick();
        bus_gnt = 1'b1;
        tick();
        bus_gnt = 1'b0;
        reset_n = 1'b0;
        #1;
        checks++;
        if (bus_req !== 1'b0 || bus_addr !== 32'h0 || mem_rvalid !== 1'b0 || if_rvalid !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: bus_req=%b bus_addr=%h mem_rvalid=%b if_rvalid=%b required all 0",
                     bus_req, bus_addr, mem_rvalid, if_rvalid);
        end
        bus_rvalid = 1'b1;
        mem_req = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
        tick();
        bus_rvalid = 1'b0;
        tick();
        checks++;
        if (mem_rvalid !== 1'b0 || if_rvalid !== 1'b0 || bus_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_stale_rvalid: mem_rvalid=%b if_rvalid=%b bus_req=%b required 0 0 0",
                     mem_rvalid, if_rvalid, bus_req);
        end
        if_req = 1'b1; if_addr = 32'h600;
        sb.push_back('{is_mem: 1'b0, we: 1'b0, addr: 32'h600, data: 32'h1234_5678, fault: 1'b0});
        serve(32'h1234_5678, seen, a, we, iv, mv, rd, flt);
        e = sb.pop_front();
        checks++;
        if (!seen || a !== e.addr || we !== e.we || iv !== 1'b1 || mv !== 1'b0 || rd !== e.data || flt !== e.fault) begin
            errors++;
            $display("FAIL reset_then_fetch: addr=%h if_rvalid=%b data=%h fault=%b required addr=%h data=%h fault=%b",
                     a, iv, rd, flt, e.addr, e.data, e.fault);
        end
        if_req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_contention();
        test_starvation();
        test_flush();
        test_timeout();
        test_reset_in_wait();
        checks++;
        if (sb.size() !== 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at time limit");
        $fatal(1);
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

- Shares the single unified memory bus between the IF stage (instruction fetch, read-only) and the MEM stage (load/store).
- Sits between the pipeline stage interfaces and the external memory bus, and generates `stall_IF` / `stall_MEM` for the pipeline control logic.
- Keeps one transaction outstanding at a time.
- Handles branch-flush cancellation of fetches, anti-starvation of IF, and bus timeout reporting as an access fault.

## Interface
Parameters:
- MAX_MEM_BURST, 4: consecutive MEM grants allowed while IF waits before IF is forced a grant.
- TIMEOUT, 255: cycles in a WAIT state without `bus_rvalid` before fault.

Ports:
- clk  in  1  single clock, all state on rising edge.
- reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
- if_req  in  1  fetch request, held until `if_rvalid` or flush.
- if_addr  in  32  fetch address.
- if_flush  in  1  took_branch: cancel current fetch.
- if_rvalid  out  1  one-cycle pulse, `if_rdata` valid.
- if_rdata  out  32  fetched word.
- if_fault  out  1  qualifies `if_rvalid`: access fault (timeout).
- mem_req  in  1  load/store request, held until `mem_rvalid`.
- mem_we  in  1  1 = store.
- mem_addr  in  32  data address.
- mem_wdata  in  32  store data.
- mem_wstrb  in  4  store byte enables.
- mem_rvalid  out  1  one-cycle pulse, load data valid or store acknowledged.
- mem_rdata  out  32  load word.
- mem_fault  out  1  qualifies `mem_rvalid`: access fault.
- stall_IF  out  1  `if_req & ~if_rvalid`.
- stall_MEM  out  1  `mem_req & ~mem_rvalid`.
- bus_req  out  1  bus request, held until `bus_gnt`.
- bus_we, bus_addr, bus_wdata, bus_wstrb  out  1/32/32/4  registered copy of the granted request.
- bus_gnt  in  1  bus accepts the request this cycle.
- bus_rvalid  in  1  response (read data or write ack).
- bus_rdata  in  32  read data.

## Operation
States:
- IDLE: no transaction in progress.
- REQ_IF / REQ_MEM: `bus_req` = 1, waiting for `bus_gnt`.
- WAIT_IF / WAIT_MEM: transaction accepted, waiting for `bus_rvalid`.
- DRAIN: a cancelled fetch is still in flight on the bus.

Transitions:
- **IDLE, arbitration:**
  - MEM wins when both requesters are active.
  - IF wins instead when `starve_cnt == MAX_MEM_BURST`.
  - The winner's address, write enable, write data and strobes are latched into the bus_* registers, and the FSM moves to REQ_x.
- **Starvation counter:**
  - `starve_cnt` increments on each MEM grant made while `if_req` is high.
  - It clears on any IF grant, or on any MEM grant made while `if_req` is low.
  - It saturates at MAX_MEM_BURST.
- **REQ_x to WAIT_x:** on `bus_gnt`.
- **WAIT_x to IDLE:** on `bus_rvalid`; `x_rvalid` pulses and `x_rdata` is taken from `bus_rdata`, both registered one cycle after `bus_rvalid`.
- **Flush:**
  - In IDLE or REQ_MEM/WAIT_MEM: `if_flush` has no effect.
  - In REQ_IF: `bus_req` is withdrawn the next cycle and the FSM returns to IDLE. Withdrawing before grant is legal on this bus.
  - In WAIT_IF: the FSM moves to DRAIN. The response is discarded when it arrives (no `if_rvalid`), then the FSM returns to IDLE.
  - Coincident with the `if_rvalid` pulse: `if_rvalid` is suppressed that cycle.
- **Timeout:**
  - The timer counts cycles in WAIT_x and DRAIN.
  - At TIMEOUT in WAIT_x: `x_rvalid` = 1 with `x_fault` = 1, `x_rdata` = 0, then IDLE.
  - At TIMEOUT in DRAIN: silent return to IDLE.
  - `bus_rvalid` seen in IDLE or REQ_x is ignored.
- **Writes:** IF never writes. `bus_we` is 0 for IF transactions.
- **Reset (asserted at any time):**
  - FSM goes to IDLE, `starve_cnt` and the timer clear, and any in-flight transaction is abandoned.
  - All outputs are 0 while reset is low and on the first cycle after release: `bus_req`, `bus_we`, `bus_addr`, `bus_wdata`, `bus_wstrb`, `if_rvalid`, `if_rdata`, `if_fault`, `mem_rvalid`, `mem_rdata`, `mem_fault`.
  - `stall_IF` / `stall_MEM` follow their combinational definitions.

## Timing
- Request seen in IDLE at cycle N: `bus_req` = 1 at cycle N+1.
- Minimum latency, `bus_gnt` at N+1 and `bus_rvalid` at N+2: `x_rvalid` at N+3.
- Back-to-back: the next arbitration occurs in the cycle `x_rvalid` pulses (state is IDLE), so the next `bus_req` follows one cycle later.
- `bus_*` payload is stable from `bus_req` rise through `bus_gnt`.
- Timeout fault pulse occurs TIMEOUT cycles after entering WAIT_x.

## Structure
- Shared package `cpu_mem_pkg`: state encoding (IDLE, REQ_IF, REQ_MEM, WAIT_IF, WAIT_MEM, DRAIN) and requester IDs (REQ_ID_IF = 0, REQ_ID_MEM = 1).
- One sub-module, `bus_timeout_counter`:
  - Inputs: `clk`, `reset`, `run`, `clear`.
  - Output: `expired`.
  - Width is `$clog2(TIMEOUT+1)`.

## Test plan
- **Single fetch:** `if_req` with `if_addr` = 0x100, `bus_gnt` at once, `bus_rvalid` one cycle later with `bus_rdata` = 0x00000013 -> `if_rvalid` pulse with `if_rdata` = 0x13, `stall_IF` low in the same cycle.
- **Contention:** `if_req` and `mem_req` (load 0x2000) asserted in the same cycle -> first `bus_addr` = 0x2000 with `bus_we` = 0, then 0x100 with `stall_IF` high throughout the MEM transaction.
- **Starvation:** `if_req` held while `mem_req` is re-asserted after every `mem_rvalid`, MAX_MEM_BURST = 4 -> the 5th grant goes to IF.
- **Flush in WAIT_IF:** `if_flush` asserted after `bus_gnt`, `bus_rvalid` 3 cycles later -> no `if_rvalid`, state DRAIN then IDLE, next fetch issued afterwards.
- **Timeout:** store with `bus_gnt` and no `bus_rvalid`, TIMEOUT = 8 -> `mem_rvalid` = 1 and `mem_fault` = 1 eight cycles after the grant, then IDLE.
- **Reset in WAIT_MEM:** `reset` driven low mid-transaction -> `bus_req` = 0 and all rvalids = 0 immediately; after release a new `if_req` is granted normally.
